// File: rtl/ps2_timebase_gen_if.sv
// Control/status bundle for the PS2 multi-channel timebase generator.
// The master drives enables, align and divisor writes; the slave returns the clocks and status.
interface ps2_timebase_gen_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0] ch_en;
    logic              align;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (
        output ch_en, align, wr_en, wr_ch, wr_div,
        input  clk_out, tick, pending
    );

    modport slave (
        input  ch_en, align, wr_en, wr_ch, wr_div,
        output clk_out, tick, pending
    );
endinterface

// File: rtl/ps2_timebase_gen.sv
// Multi-channel square-wave timebase with run-time reprogrammable half-period divisors.
// A new divisor sits in a shadow register until the channel's next half-period boundary.
module ps2_timebase_gen #(
    parameter int                        NUM_CH  = 2,
    parameter int                        CNT_W   = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   DEF_DIV = {16'd25500, 16'd150}
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    ps2_timebase_gen_if.slave    bus
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            localparam logic [CNT_W-1:0] DEF_CH = DEF_DIV[gi*CNT_W +: CNT_W];

            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] active_div_reg;
            logic [CNT_W-1:0] shadow_div_reg;
            logic             clk_reg;
            logic             tick_reg;
            logic             pending_reg;
            logic [CNT_W-1:0] eff_div;
            logic             wrap;
            logic             wr_hit;

            // A zero divisor behaves as one, giving the fastest 2-cycle period.
            assign eff_div = (active_div_reg == '0) ? ONE : active_div_reg;
            assign wrap    = (cnt_reg == eff_div - ONE);
            // Out-of-range channel numbers never match any gi, so they fall away here.
            assign wr_hit  = bus.wr_en && (bus.wr_ch == 3'(gi));

            always_ff @(posedge sys_clk) begin
                if (rst) begin
                    cnt_reg        <= '0;
                    clk_reg        <= 1'b0;
                    tick_reg       <= 1'b0;
                    pending_reg    <= 1'b0;
                    active_div_reg <= DEF_CH;
                    shadow_div_reg <= DEF_CH;
                end else if (bus.align) begin
                    cnt_reg     <= '0;
                    clk_reg     <= 1'b0;
                    tick_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                    if (wr_hit) begin
                        active_div_reg <= bus.wr_div;
                        shadow_div_reg <= bus.wr_div;
                    end else begin
                        active_div_reg <= shadow_div_reg;
                    end
                end else begin
                    tick_reg <= 1'b0;
                    if (wr_hit) begin
                        shadow_div_reg <= bus.wr_div;
                    end
                    if (bus.ch_en[gi] && wrap) begin
                        cnt_reg     <= '0;
                        clk_reg     <= ~clk_reg;
                        tick_reg    <= ~clk_reg;
                        pending_reg <= 1'b0;
                        // A write landing on the boundary takes effect immediately.
                        active_div_reg <= wr_hit ? bus.wr_div : shadow_div_reg;
                    end else begin
                        if (bus.ch_en[gi]) begin
                            cnt_reg <= cnt_reg + ONE;
                        end
                        if (wr_hit) begin
                            pending_reg <= 1'b1;
                        end
                    end
                end
            end

            assign bus.clk_out[gi] = clk_reg;
            assign bus.tick[gi]    = tick_reg;
            assign bus.pending[gi] = pending_reg;
        end
    endgenerate

endmodule

// File: tb/tb_ps2_timebase_gen.sv
// Directed bench for ps2_timebase_gen: a vector table on small divisors plus
// long sequences for the default periods, runtime reprogram and mid-period reset.
module tb_ps2_timebase_gen;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 sys_clk = ~sys_clk;

    ps2_timebase_gen_if #(.NUM_CH(2), .CNT_W(16)) bus ();

    ps2_timebase_gen #(
        .NUM_CH (2),
        .CNT_W  (16),
        .DEF_DIV({16'd25500, 16'd150})
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [1:0]  en;
        logic        al;
        logic        we;
        logic [2:0]  wch;
        logic [15:0] wdiv;
        logic [1:0]  e_clk;
        logic [1:0]  e_tick;
        logic [1:0]  e_pend;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic al, input logic we,
                         input logic [2:0] wch, input logic [15:0] wdiv);
        bus.ch_en  = en;
        bus.align  = al;
        bus.wr_en  = we;
        bus.wr_ch  = wch;
        bus.wr_div = wdiv;
    endtask

    initial begin
        int t0_cnt;
        int t1_cnt;
        int first1;
        int tk_late;
        int tk_early;

        // Divisors 2/3 after the align, then disable, zero-divisor and coincident writes.
        vecs[0]  = '{2'b00, 1'b0, 1'b1, 3'd0, 16'd2, 2'b00, 2'b00, 2'b01};
        vecs[1]  = '{2'b00, 1'b0, 1'b1, 3'd1, 16'd3, 2'b00, 2'b00, 2'b11};
        vecs[2]  = '{2'b00, 1'b0, 1'b1, 3'd5, 16'd9, 2'b00, 2'b00, 2'b11};
        vecs[3]  = '{2'b00, 1'b1, 1'b0, 3'd0, 16'd0, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b01, 2'b01, 2'b00};
        vecs[6]  = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b11, 2'b10, 2'b00};
        vecs[7]  = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b10, 2'b00, 2'b00};
        vecs[8]  = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b10, 2'b00, 2'b00};
        vecs[9]  = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b01, 2'b01, 2'b00};
        vecs[10] = '{2'b01, 1'b0, 1'b1, 3'd1, 16'd1, 2'b01, 2'b00, 2'b10};
        vecs[11] = '{2'b01, 1'b0, 1'b0, 3'd0, 16'd0, 2'b00, 2'b00, 2'b10};
        vecs[12] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b00, 2'b00, 2'b10};
        vecs[13] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b01, 2'b01, 2'b10};
        vecs[14] = '{2'b11, 1'b0, 1'b1, 3'd0, 16'd0, 2'b11, 2'b10, 2'b01};
        vecs[15] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b00, 2'b00, 2'b00};
        vecs[16] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b11, 2'b11, 2'b00};
        vecs[17] = '{2'b11, 1'b0, 1'b1, 3'd1, 16'd3, 2'b00, 2'b00, 2'b00};
        vecs[18] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b01, 2'b01, 2'b00};
        vecs[19] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b00, 2'b00, 2'b00};
        vecs[20] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b11, 2'b11, 2'b00};
        vecs[21] = '{2'b00, 1'b1, 1'b1, 3'd1, 16'd5, 2'b00, 2'b00, 2'b00};
        vecs[22] = '{2'b11, 1'b0, 1'b0, 3'd0, 16'd0, 2'b01, 2'b01, 2'b00};

        // Reset state
        drive(2'b00, 1'b0, 1'b0, 3'd0, 16'd0);
        rst = 1'b1;
        step();
        step();
        chk("rst_clk", 32'(bus.clk_out), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        chk("rst_pend", 32'(bus.pending), 32'h0);
        $display("reset: clk=%b tick=%b pend=%b", bus.clk_out, bus.tick, bus.pending);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].en, vecs[i].al, vecs[i].we, vecs[i].wch, vecs[i].wdiv);
            step();
            $display("vec %0d: en=%b al=%b we=%b ch=%0d div=%0d -> clk=%b tick=%b pend=%b",
                     i, vecs[i].en, vecs[i].al, vecs[i].we, vecs[i].wch, vecs[i].wdiv,
                     bus.clk_out, bus.tick, bus.pending);
            chk($sformatf("vec%0d_clk", i), 32'(bus.clk_out), 32'(vecs[i].e_clk));
            chk($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vecs[i].e_tick));
            chk($sformatf("vec%0d_pend", i), 32'(bus.pending), 32'(vecs[i].e_pend));
        end

        // Default divisors: ch0 ticks at 150, 450, ...; ch1 first rises at 25500.
        drive(2'b00, 1'b0, 1'b0, 3'd0, 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ch_en = 2'b11;
        t0_cnt = 0;
        t1_cnt = 0;
        first1 = 0;
        for (int e = 1; e <= 25500; e++) begin
            step();
            if (bus.tick[0]) t0_cnt++;
            if (bus.tick[1]) begin
                t1_cnt++;
                if (first1 == 0) first1 = e;
            end
            if (e == 149) chk("def_tick0_149", 32'(bus.tick[0]), 32'h0);
            if (e == 150) chk("def_tick0_150", 32'(bus.tick[0]), 32'h1);
            if (e == 300) chk("def_clk0_300", 32'(bus.clk_out[0]), 32'h0);
        end
        $display("defaults: ch0 ticks=%0d ch1 ticks=%0d first ch1 tick=%0d", t0_cnt, t1_cnt, first1);
        chk("def_tick0_count", 32'(t0_cnt), 32'd85);
        chk("def_tick1_count", 32'(t1_cnt), 32'd1);
        chk("def_tick1_first", 32'(first1), 32'd25500);
        chk("def_clk1_high", 32'(bus.clk_out[1]), 32'h1);

        // Runtime reprogram of ch0 to 4 mid-half-period: takes effect at the wrap at 300.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ch_en = 2'b01;
        tk_late = 0;
        for (int e = 1; e <= 320; e++) begin
            bus.wr_en  = (e == 161);
            bus.wr_ch  = 3'd0;
            bus.wr_div = 16'd4;
            step();
            if (e > 300 && bus.tick[0]) tk_late++;
            if (e == 161) chk("rp_pend_161", 32'(bus.pending[0]), 32'h1);
            if (e == 299) chk("rp_pend_299", 32'(bus.pending[0]), 32'h1);
            if (e == 300) chk("rp_pend_300", 32'(bus.pending[0]), 32'h0);
            if (e == 300) chk("rp_clk_300", 32'(bus.clk_out[0]), 32'h0);
            if (e == 303) chk("rp_clk_303", 32'(bus.clk_out[0]), 32'h0);
            if (e == 304) chk("rp_tick_304", 32'(bus.tick[0]), 32'h1);
            if (e == 308) chk("rp_clk_308", 32'(bus.clk_out[0]), 32'h0);
            if (e == 312) chk("rp_tick_312", 32'(bus.tick[0]), 32'h1);
        end
        $display("reprogram: ticks after wrap=%0d", tk_late);
        chk("rp_tick_count", 32'(tk_late), 32'd3);

        // Reset mid-period beats a simultaneous write; divisor returns to 150.
        drive(2'b11, 1'b0, 1'b1, 3'd1, 16'd9);
        rst = 1'b1;
        step();
        chk("mrst_clk", 32'(bus.clk_out), 32'h0);
        chk("mrst_tick", 32'(bus.tick), 32'h0);
        chk("mrst_pend", 32'(bus.pending), 32'h0);
        rst = 1'b0;
        drive(2'b11, 1'b0, 1'b0, 3'd0, 16'd0);
        tk_early = 0;
        for (int e = 1; e <= 150; e++) begin
            step();
            if (e < 150 && bus.tick[0]) tk_early++;
            if (e == 150) chk("mrst_tick0_150", 32'(bus.tick[0]), 32'h1);
        end
        $display("post-reset: early ticks=%0d", tk_early);
        chk("mrst_early_ticks", 32'(tk_early), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_timebase_gen.md
Name: ps2_timebase_gen

Overview:
- Parametrised multi-channel timebase generator for the PS2 subsystem. It derives NUM_CH independent square-wave clocks and rising-edge tick strobes from sys_clk.
- Each channel has a half-period divisor that software can reprogram at run time. New values are applied glitch-free at the channel's next half-period boundary.
- Adds per-channel enable, a global phase-align strobe and a pending-update status, none of which exist in the fixed two-output divider.
- Feeds the PS2 bit sampler (6 us) and the inhibit/timeout logic (1020 us).

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- CNT_W, 16, width of the divisor and counter per channel.
- DEF_DIV, {16'd25500, 16'd150}, packed NUM_CH*CNT_W reset half-period values. Channel 0 occupies the LSBs. At 50 MHz the defaults give 6 us on ch0 and 1020 us on ch1.

Ports:
- sys_clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- ch_en  in  NUM_CH  per-channel run enable.
- align  in  1  one-cycle strobe; restarts every channel in phase.
- wr_en  in  1  divisor write strobe.
- wr_ch  in  3  target channel of the write.
- wr_div  in  CNT_W  new half-period, in sys_clk cycles.
- clk_out  out  NUM_CH  square outputs, period 2*div, 50 % duty.
- tick  out  NUM_CH  one-cycle pulse, asserted in the same cycle clk_out[ch] goes 0->1.
- pending  out  NUM_CH  1 while a written divisor is waiting to become active.

Behaviour:
- Reset (rst=1 at a sys_clk edge):
  - cnt = 0, clk_out = 0, tick = 0, pending = 0.
  - active_div and shadow_div are both loaded from their DEF_DIV slice.
  - rst has priority over every other input.
- Divisor value 0 is treated as 1 (clamp), so the minimum period is 2 cycles.
- Per channel ch, when ch_en[ch]=1 and no align:
  - If cnt == eff_div-1, this is a wrap. Then cnt <= 0 and clk_out toggles.
  - On a wrap, active_div <= shadow_div and pending <= 0.
  - Otherwise cnt <= cnt+1.
  - eff_div is active_div after the clamp.
- tick[ch]:
  - Registered; high for exactly one cycle, the cycle in which clk_out[ch] is first 1 after a 0->1 toggle.
  - 0 in all other cycles.
- Disable (ch_en[ch]=0):
  - cnt and clk_out hold their values; tick = 0.
  - Divisor writes are still accepted into the shadow, and pending is set.
  - Re-enabling resumes the count from the held cnt.
- Write (wr_en=1, wr_ch < NUM_CH):
  - shadow_div[wr_ch] <= wr_div and pending[wr_ch] <= 1, in the cycle after the write.
  - Writes with wr_ch >= NUM_CH are ignored with no side effects.
- Write in the same cycle as a wrap of that channel: the new wr_div is bypassed straight into active_div, and pending stays 0.
- Back-to-back writes: the last write before the wrap wins.
- align=1:
  - All channels: cnt <= 0, clk_out <= 0, tick <= 0, active_div <= shadow_div, pending <= 0.
  - This applies regardless of ch_en.
  - If wr_en is also high, wr_div is loaded directly into the target's active_div.
- Channels are fully independent. No cross-channel arbitration is needed; wr_ch selects one channel.
- Counter arithmetic is unsigned CNT_W with no overflow possible, because cnt < eff_div <= 2^CNT_W-1.
- Latency: the first rising edge of clk_out appears eff_div cycles after reset release or align, with tick high in that same cycle. Rising edges then repeat every 2*eff_div cycles.

Test Plan:
- Default config after rst, ch_en=2'b11, run 200,000 cycles:
  - clk_out[0] toggles every 150 cycles (period 300); clk_out[1] period 51000.
  - tick[0] fires at cycles 150, 450, 750, ...
- Runtime reprogram: ch0 running with div 150, write wr_ch=0, wr_div=4 mid-half-period.
  - pending[0]=1 until the next wrap.
  - The current half-period completes at 150; thereafter period is 8.
  - No runt pulses shorter than 4 cycles.
- Write coincident with wrap: wr_div=3 issued on the exact wrap cycle.
  - The next half-period is 3 cycles; pending[0] is never set.
- Enable gating: drop ch_en[1] for 1000 cycles mid-count.
  - clk_out[1] and cnt freeze; tick[1] stays 0.
  - On re-enable the remaining count resumes, and total high time equals 25500 enabled cycles.
- Align: ch0 div=5, ch1 div=7 running out of phase; pulse align.
  - Both clk_out go to 0 next cycle.
  - The first ticks occur at +5 and +7 cycles respectively.
- Edge cases:
  - wr_div=0 gives period 2.
  - wr_ch=5 with NUM_CH=2 leaves all state unchanged.
  - rst asserted mid-period returns all outputs to 0 and divisors to 150/25500 on the next edge.
